// File: rtl/uart_cal_pkg.sv
// rtl/uart_cal_pkg.sv - shared types and ASCII constants for the UART calculator
// Sequencer state encoding, character codes and the default result width.
package uart_cal_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ECHO,
    ST_EQ,
    ST_DIGIT,
    ST_CR,
    ST_LF,
    ST_WAIT
  } seq_state_t;

  localparam logic [7:0] ASC_EQ = 8'h3D;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_A  = 8'h41;

  localparam int unsigned NUM_DIGITS_DEF = 8;
  localparam int unsigned CNT_W          = 3;

endpackage

// File: rtl/hex2ascii.sv
// rtl/hex2ascii.sv - nibble to uppercase ASCII hex character
// Purely combinational; shared with the receive-side decoder checks.
module hex2ascii
  import uart_cal_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [7:0] o_ascii
);

  always_comb begin
    if (i_nib < 4'd10) begin
      o_ascii = ASC_0 + {4'h0, i_nib};
    end else begin
      o_ascii = ASC_A + {4'h0, i_nib} - 8'd10;
    end
  end

endmodule

// File: rtl/uart_tx_sequencer.sv
// rtl/uart_tx_sequencer.sv - shares one UART transmitter between echo bytes and result strings
// Optional CR/LF suffix after the hex digits: UART_TX_CRLF_EN.
module uart_tx_sequencer
  import uart_cal_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEF
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        i_alu_done,
  input  logic [31:0] i_calc_res,
  input  logic        i_echo_valid,
  input  logic [7:0]  i_echo_data,
  output logic        o_echo_ready,
  input  logic        i_tx_busy,
  output logic        o_tx_start,
  output logic [7:0]  o_tx_data,
  output logic        o_seq_busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(NUM_DIGITS - 1);

  seq_state_t       r_state, w_state_nxt;
  seq_state_t       r_ret, w_ret_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]      r_res, w_res_nxt;
  logic [7:0]       r_echo, w_echo_nxt;
  logic             r_pend_v, w_pend_v_nxt;
  logic [31:0]      r_pend_q, w_pend_q_nxt;
  logic             r_tx_start, w_tx_start_nxt;
  logic [7:0]       r_tx_data, w_tx_data_nxt;

  logic [3:0]       w_nib;
  logic [7:0]       w_digit_ascii;
  logic [7:0]       w_send_byte;
  logic             w_can_leave;

  assign w_nib = r_res[{r_cnt, 2'b00} +: 4];

  hex2ascii u_hex2ascii (
    .i_nib   (w_nib),
    .o_ascii (w_digit_ascii)
  );

  // The start pulse is still high in the first WAIT cycle while busy has not risen yet.
  assign w_can_leave = !i_tx_busy && !r_tx_start;

  always_comb begin
    w_send_byte = r_echo;
    case (r_state)
      ST_EQ:    w_send_byte = ASC_EQ;
      ST_DIGIT: w_send_byte = w_digit_ascii;
      ST_CR:    w_send_byte = ASC_CR;
      ST_LF:    w_send_byte = ASC_LF;
      default:  w_send_byte = r_echo;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ret_nxt      = r_ret;
    w_cnt_nxt      = r_cnt;
    w_res_nxt      = r_res;
    w_echo_nxt     = r_echo;
    w_pend_v_nxt   = r_pend_v;
    w_pend_q_nxt   = r_pend_q;
    w_tx_start_nxt = 1'b0;
    w_tx_data_nxt  = r_tx_data;

    if (i_alu_done && (r_state != ST_IDLE)) begin
      w_pend_v_nxt = 1'b1;
      w_pend_q_nxt = i_calc_res;
    end

    case (r_state)
      ST_IDLE: begin
        if (i_alu_done) begin
          // A fresh result supersedes anything still pending.
          w_res_nxt    = i_calc_res;
          w_cnt_nxt    = CNT_LOAD;
          w_pend_v_nxt = 1'b0;
          w_state_nxt  = ST_EQ;
        end else if (r_pend_v) begin
          w_res_nxt    = r_pend_q;
          w_cnt_nxt    = CNT_LOAD;
          w_pend_v_nxt = 1'b0;
          w_state_nxt  = ST_EQ;
        end else if (i_echo_valid) begin
          w_echo_nxt  = i_echo_data;
          w_state_nxt = ST_ECHO;
        end
      end

      ST_ECHO, ST_EQ, ST_DIGIT: begin
        if (!i_tx_busy) begin
          w_tx_start_nxt = 1'b1;
          w_tx_data_nxt  = w_send_byte;
          w_ret_nxt      = r_state;
          w_state_nxt    = ST_WAIT;
        end
      end

`ifdef UART_TX_CRLF_EN
      ST_CR, ST_LF: begin
        if (!i_tx_busy) begin
          w_tx_start_nxt = 1'b1;
          w_tx_data_nxt  = w_send_byte;
          w_ret_nxt      = r_state;
          w_state_nxt    = ST_WAIT;
        end
      end
`endif

      ST_WAIT: begin
        if (w_can_leave) begin
          case (r_ret)
            ST_EQ: w_state_nxt = ST_DIGIT;
            ST_DIGIT: begin
              if (r_cnt == '0) begin
`ifdef UART_TX_CRLF_EN
                w_state_nxt = ST_CR;
`else
                w_state_nxt = ST_IDLE;
`endif
              end else begin
                w_cnt_nxt   = r_cnt - CNT_W'(1);
                w_state_nxt = ST_DIGIT;
              end
            end
`ifdef UART_TX_CRLF_EN
            ST_CR:   w_state_nxt = ST_LF;
`endif
            default: w_state_nxt = ST_IDLE;
          endcase
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= ST_IDLE;
      r_ret      <= ST_IDLE;
      r_cnt      <= '0;
      r_res      <= '0;
      r_echo     <= '0;
      r_pend_v   <= 1'b0;
      r_pend_q   <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_ret      <= w_ret_nxt;
      r_cnt      <= w_cnt_nxt;
      r_res      <= w_res_nxt;
      r_echo     <= w_echo_nxt;
      r_pend_v   <= w_pend_v_nxt;
      r_pend_q   <= w_pend_q_nxt;
      r_tx_start <= w_tx_start_nxt;
      r_tx_data  <= w_tx_data_nxt;
    end
  end

  assign o_echo_ready = (r_state == ST_IDLE) && !i_alu_done && !r_pend_v;
  assign o_tx_start   = r_tx_start;
  assign o_tx_data    = r_tx_data;
  assign o_seq_busy   = (r_state != ST_IDLE);

endmodule

// File: doc/uart_tx_sequencer.md
# uart_tx_sequencer

UART calculator transmit scheduler. Shares one byte-wide UART transmitter between two requesters:
- **Echo path:** single received characters.
- **Result path:** a formatted answer string built from the 32-bit ALU result.

It sits between the ALU/echo logic and the UART TX serialiser. It sequences the result string `=`, hex digits and optional CR/LF one byte at a time over a start/busy handshake.

## Interface
- `NUM_DIGITS`, default 8: hex digits of `calc_res` sent, range 1..8. Sends the low `NUM_DIGITS` nibbles, most significant first.
- `clk` input 1: clock.
- `n_rst` input 1: reset, asynchronous, active-low.
- `alu_done` input 1: one-cycle pulse, `calc_res` valid.
- `calc_res` input 32: ALU result, sampled with `alu_done`.
- `echo_valid` input 1: echo byte request.
- `echo_data` input 8: echo byte.
- `echo_ready` output 1: echo byte accepted when `echo_valid && echo_ready`.
- `tx_busy` input 1: serialiser busy. Rises the cycle after `tx_start` is sampled; low when the line is idle.
- `tx_start` output 1: registered one-cycle pulse, `tx_data` valid.
- `tx_data` output 8: registered byte to transmit.
- `seq_busy` output 1: high in any state except IDLE.

## Operation
- **States:** IDLE, ECHO, EQ, DIGIT, CR, LF, WAIT. WAIT records its return target.
- **IDLE:**
  - `alu_done` → capture `calc_res` into `res_q`, load digit counter with `NUM_DIGITS-1`, go to EQ.
  - Otherwise a pending result → load from `pend_q`, go to EQ.
  - Otherwise `echo_valid` → capture `echo_data`, go to ECHO.
- **Priority:** result wins over echo in the same cycle. `echo_ready = (state==IDLE) && !alu_done && !pend_v`, combinational.
- **Send states (ECHO, EQ, DIGIT, CR, LF):** when `tx_busy==0`, register `tx_start=1` and the byte, then go to WAIT.
  - ECHO byte: the echo byte.
  - EQ byte: 8'h3D.
  - DIGIT byte: ASCII of nibble `res_q[4*cnt+3:4*cnt]`.
  - CR byte: 8'h0D. LF byte: 8'h0A.
- **WAIT:** leaves when `tx_busy==0`. It cannot leave in the cycle it is entered.
  - After EQ → DIGIT.
  - After DIGIT with `cnt==0` → CR, or IDLE without CRLF.
  - After DIGIT with `cnt>0` → decrement `cnt`, DIGIT.
  - After LF or ECHO → IDLE.
- **Hex to ASCII:** 0-9 → 8'h30-8'h39; A-F → 8'h41-8'h46, uppercase.
- **Pending:** `alu_done` while `seq_busy` sets `pend_v` and writes `pend_q`. A second `alu_done` while pending overwrites `pend_q`: latest wins, one deep. `pend_v` clears when loaded in IDLE.
- **Echo while busy:** held off with `echo_ready=0`; never dropped by this block.

## Timing
- **Reset values:** `tx_start=0`, `tx_data=8'h00`, `seq_busy=0`, state IDLE, `pend_v=0`, `cnt=0`. `echo_ready` follows its equation, so it is 1 with `alu_done=0`.
- **Latency:** `alu_done` sampled at edge N with idle line → `tx_start` high in cycle N+1 with `tx_data=8'h3D`.
- **Pulse width:** `tx_start` is exactly one cycle wide. It is never asserted while `tx_busy=1`. `tx_data` holds its value until the next `tx_start`.
- **Spacing:** minimum spacing between `tx_start` pulses is 3 cycles.
- **Mid-string reset:** `n_rst` low aborts immediately. No further `tx_start`; the pending result is lost.
- **Return to IDLE:** after the last byte's WAIT exit → IDLE. A pending result starts EQ on the next cycle.

## Configuration
- **`UART_TX_CRLF_EN` defined:** CR (8'h0D) then LF (8'h0A) are appended after the last digit. Result string is `NUM_DIGITS+3` bytes.
- **Not defined:** CR/LF states are not compiled. WAIT after the last digit → IDLE. String is `NUM_DIGITS+1` bytes.

## Structure
- **Shared package `uart_cal_pkg`:**
  - State typedef.
  - ASCII constants: EQ 8'h3D, CR 8'h0D, LF 8'h0A, 0 8'h30, A 8'h41.
  - Default `NUM_DIGITS`.
- **Sub-module `hex2ascii`:** combinational, 4-bit nibble in, 8-bit ASCII out. Also reused by the decoder's inverse checks.

## Test plan
- **Basic result:** `calc_res=32'h1234_ABCD` pulse, model `tx_busy` 10 cycles per byte. Expect bytes 3D 31 32 33 34 41 42 43 44, then 0D 0A with CRLF; one `tx_start` per byte, none while busy.
- **Priority:** `echo_valid` with 8'h35 and `alu_done` in the same IDLE cycle. Expect result string first, `echo_ready=0`; then 35 sent after the string.
- **Pending overwrite:** two `alu_done` (32'h1, then 32'h2) during a string. Expect the current string completes, then exactly one extra string ending in digit 32; `32'h1` is never sent.
- **Digit count:** `NUM_DIGITS=2`, `calc_res=32'h0000_00F9`. Expect 3D 46 39 (+0D 0A); `seq_busy` falls after the last WAIT.
- **Reset mid-string:** `n_rst` low after the third byte. Expect `tx_start=0`, `tx_data=8'h00`, IDLE, `pend_v` clear; no bytes after release until a new `alu_done`.
